// File: rtl/washer_pkg.sv
// -----------------------------------------------------------------------------
// washer_pkg
// Shared definitions for the parametrised washing machine controller:
//   - wm_state_e  : 4-bit state encoding (also exported on the debug port)
//   - PH_SOAP / PH_RINSE : wash phase flag values
//   - clamp_rinse : limits the front-panel rinse selection to MAX_RINSE
//   - is_locked_run / is_pausable : state-class helpers used by the FSM
// -----------------------------------------------------------------------------
package washer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CHECK_DOOR = 4'd1,
        ST_FILL       = 4'd2,
        ST_ADD_DET    = 4'd3,
        ST_AGITATE    = 4'd4,
        ST_DRAIN      = 4'd5,
        ST_SPIN       = 4'd6,
        ST_DONE       = 4'd7,
        ST_FAULT      = 4'd8
    } wm_state_e;

    localparam logic PH_SOAP  = 1'b0;
    localparam logic PH_RINSE = 1'b1;

    // Saturate the requested rinse count at the configured maximum.
    function automatic int unsigned clamp_rinse(input int unsigned sel,
                                                input int unsigned max_rinse);
        int unsigned result;
        if (sel > max_rinse) begin
            result = max_rinse;
        end else begin
            result = sel;
        end
        return result;
    endfunction

    // Running states in which the door is latched and must stay closed.
    function automatic logic is_locked_run(input wm_state_e st);
        logic result;
        case (st)
            ST_FILL, ST_ADD_DET, ST_AGITATE, ST_DRAIN, ST_SPIN: result = 1'b1;
            default:                                            result = 1'b0;
        endcase
        return result;
    endfunction

    // States whose timer/watchdog and actuators respond to pause.
    function automatic logic is_pausable(input wm_state_e st);
        logic result;
        case (st)
            ST_FILL, ST_AGITATE, ST_DRAIN, ST_SPIN: result = 1'b1;
            default:                                result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// -----------------------------------------------------------------------------
// wm_phase_timer
// Shared phase timer for the washing machine controller. One CNT_W-bit
// down-counter serves both the agitate/spin durations and the fill/drain
// watchdogs, since only one of them is ever live at a time.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (takes priority over hold)
//   load_val in   CNT_W value to load
//   hold     in   freeze the count (pause)
//   is_zero  out  count currently reads zero
// -----------------------------------------------------------------------------
module wm_phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt_r;

    // Down-counter: load wins, then hold, then decrement and stick at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign is_zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/washing_machine_ctrl_param.sv
// -----------------------------------------------------------------------------
// washing_machine_ctrl_param
// Automatic washing machine sequencer: door check, fill, detergent, soap
// agitate, drain, a selectable number of rinse passes, spin, done. Phase
// durations and fill/drain watchdogs come from one internal timer. An open
// door in any running state, or a watchdog expiry, latches FAULT until reset.
//
// Ports:
//   clk, reset        clock (rising edge) and async active-high reset
//   start             level; starts a program from IDLE, DONE waits for it low
//   door_close        door sensor (1 = closed)
//   pause             freezes FILL/AGITATE/DRAIN/SPIN
//   filled, drained, detergent_added   tank and detergent sensors
//   rinse_sel [RW]    number of rinse passes, sampled on start
//   door_lock, motor_on, fill_valve_on, drain_valve_on   actuators
//   soap_wash, water_wash   agitate-phase indicators
//   done, error       program complete / fault latched
//   state [4]         current state encoding (debug)
//   rinse_left [RW]   rinse passes still to run
// -----------------------------------------------------------------------------
module washing_machine_ctrl_param
    import washer_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WASH_TICKS  = 100,
    parameter int unsigned RINSE_TICKS = 50,
    parameter int unsigned SPIN_TICKS  = 40,
    parameter int unsigned FILL_TMO    = 200,
    parameter int unsigned DRAIN_TMO   = 200,
    parameter int unsigned MAX_RINSE   = 3,
    // Derived width of the rinse counter; leave at its default.
    parameter int unsigned RW          = $clog2(MAX_RINSE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          door_close,
    input  logic          pause,
    input  logic          filled,
    input  logic          drained,
    input  logic          detergent_added,
    input  logic [RW-1:0] rinse_sel,
    output logic          door_lock,
    output logic          motor_on,
    output logic          fill_valve_on,
    output logic          drain_valve_on,
    output logic          soap_wash,
    output logic          water_wash,
    output logic          done,
    output logic          error,
    output logic [3:0]    state,
    output logic [RW-1:0] rinse_left
);

    wm_state_e        state_r;
    wm_state_e        nxt_state_s;
    logic             phase_r;
    logic             nxt_phase_s;
    logic [RW-1:0]    rinse_left_r;
    logic [RW-1:0]    nxt_rinse_s;

    logic             paused_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;

    assign paused_s = is_pausable(state_r) && pause;

    // Next-state, phase and rinse-count decision; door-open fault overrides all.
    always_comb begin
        nxt_state_s = state_r;
        nxt_phase_s = phase_r;
        nxt_rinse_s = rinse_left_r;
        if (is_locked_run(state_r) && !door_close) begin
            nxt_state_s = ST_FAULT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nxt_state_s = ST_CHECK_DOOR;
                        nxt_phase_s = PH_SOAP;
                        nxt_rinse_s = RW'(clamp_rinse(32'(rinse_sel), MAX_RINSE));
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end
                ST_CHECK_DOOR: begin
                    if (door_close) begin
                        nxt_state_s = ST_FILL;
                    end else begin
                        nxt_state_s = ST_CHECK_DOOR;
                    end
                end
                ST_FILL: begin
                    // A sensor hit wins over the watchdog in the same cycle.
                    if (paused_s) begin
                        nxt_state_s = ST_FILL;
                    end else if (filled) begin
                        nxt_state_s = (phase_r == PH_SOAP) ? ST_ADD_DET : ST_AGITATE;
                    end else if (tmr_zero_s) begin
                        nxt_state_s = ST_FAULT;
                    end else begin
                        nxt_state_s = ST_FILL;
                    end
                end
                ST_ADD_DET: begin
                    if (detergent_added) begin
                        nxt_state_s = ST_AGITATE;
                    end else begin
                        nxt_state_s = ST_ADD_DET;
                    end
                end
                ST_AGITATE: begin
                    if (paused_s) begin
                        nxt_state_s = ST_AGITATE;
                    end else if (tmr_zero_s) begin
                        nxt_state_s = ST_DRAIN;
                    end else begin
                        nxt_state_s = ST_AGITATE;
                    end
                end
                ST_DRAIN: begin
                    if (paused_s) begin
                        nxt_state_s = ST_DRAIN;
                    end else if (drained) begin
                        if (rinse_left_r != {RW{1'b0}}) begin
                            nxt_state_s = ST_FILL;
                            nxt_phase_s = PH_RINSE;
                            nxt_rinse_s = rinse_left_r - RW'(1'b1);
                        end else begin
                            nxt_state_s = ST_SPIN;
                        end
                    end else if (tmr_zero_s) begin
                        nxt_state_s = ST_FAULT;
                    end else begin
                        nxt_state_s = ST_DRAIN;
                    end
                end
                ST_SPIN: begin
                    if (paused_s) begin
                        nxt_state_s = ST_SPIN;
                    end else if (tmr_zero_s) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_state_s = ST_SPIN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    nxt_state_s = ST_FAULT;
                end
                default: begin
                    // Unreachable encodings are treated as a fault.
                    nxt_state_s = ST_FAULT;
                end
            endcase
        end
    end

    // Timer reload on every state change; the value is N-1 so a phase lasts N cycles.
    always_comb begin
        tmr_load_s = (nxt_state_s != state_r);
        case (nxt_state_s)
            ST_FILL:    tmr_val_s = CNT_W'(FILL_TMO - 32'd1);
            ST_DRAIN:   tmr_val_s = CNT_W'(DRAIN_TMO - 32'd1);
            ST_SPIN:    tmr_val_s = CNT_W'(SPIN_TICKS - 32'd1);
            ST_AGITATE: begin
                if (nxt_phase_s == PH_SOAP) begin
                    tmr_val_s = CNT_W'(WASH_TICKS - 32'd1);
                end else begin
                    tmr_val_s = CNT_W'(RINSE_TICKS - 32'd1);
                end
            end
            default:    tmr_val_s = {CNT_W{1'b0}};
        endcase
    end

    wm_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .hold     (paused_s),
        .is_zero  (tmr_zero_s)
    );

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            phase_r      <= PH_SOAP;
            rinse_left_r <= {RW{1'b0}};
        end else begin
            state_r      <= nxt_state_s;
            phase_r      <= nxt_phase_s;
            rinse_left_r <= nxt_rinse_s;
        end
    end

    // Moore decode of the state register; pause only gates motor and valves so
    // the lock and the wash-phase indicators stay visible while frozen.
    assign door_lock      = is_locked_run(state_r) || (state_r == ST_FAULT);
    assign motor_on       = ((state_r == ST_AGITATE) || (state_r == ST_SPIN)) && !paused_s;
    assign fill_valve_on  = (state_r == ST_FILL) && !paused_s;
    assign drain_valve_on = ((state_r == ST_DRAIN) || (state_r == ST_SPIN)) && !paused_s;
    assign soap_wash      = (state_r == ST_AGITATE) && (phase_r == PH_SOAP);
    assign water_wash     = (state_r == ST_AGITATE) && (phase_r == PH_RINSE);
    assign done           = (state_r == ST_DONE);
    assign error          = (state_r == ST_FAULT);
    assign state          = state_r;
    assign rinse_left     = rinse_left_r;

endmodule

// File: tb/tb_washing_machine_ctrl_param.sv
// Directed bench for washing_machine_ctrl_param with short phase durations.
module tb_washing_machine_ctrl_param;

    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          door_close;
    logic          pause;
    logic          filled;
    logic          drained;
    logic          detergent_added;
    logic [RW-1:0] rinse_sel;
    logic          door_lock;
    logic          motor_on;
    logic          fill_valve_on;
    logic          drain_valve_on;
    logic          soap_wash;
    logic          water_wash;
    logic          done;
    logic          error;
    logic [3:0]    state;
    logic [RW-1:0] rinse_left;

    int n_checks = 0;
    int n_errors = 0;

    // Recorded by run_prog
    logic [3:0] seq_q[$];
    int soap_len, soap_moff, spin_len, spin_moff, spin_doff, lock_drops;
    int water_passes, rinse_at_spin, rinse_at_chk;
    int water_len[4];
    bit opt_pause_agit, opt_pause_spin, opt_door_drop, opt_reset_spin;

    logic [3:0] exp_seq2[13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd2, 4'd4, 4'd5,
                                 4'd2, 4'd4, 4'd5, 4'd6, 4'd7};

    washing_machine_ctrl_param #(
        .CNT_W       (16),
        .WASH_TICKS  (8),
        .RINSE_TICKS (4),
        .SPIN_TICKS  (6),
        .FILL_TMO    (10),
        .DRAIN_TMO   (10),
        .MAX_RINSE   (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .door_close      (door_close),
        .pause           (pause),
        .filled          (filled),
        .drained         (drained),
        .detergent_added (detergent_added),
        .rinse_sel       (rinse_sel),
        .door_lock       (door_lock),
        .motor_on        (motor_on),
        .fill_valve_on   (fill_valve_on),
        .drain_valve_on  (drain_valve_on),
        .soap_wash       (soap_wash),
        .water_wash      (water_wash),
        .done            (done),
        .error           (error),
        .state           (state),
        .rinse_left      (rinse_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs_vec();
        return {door_lock, motor_on, fill_valve_on, drain_valve_on,
                soap_wash, water_wash, done, error};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one program with sensors answering 2 cycles after each state entry.
    task automatic run_prog(input int budget);
        int         in_cnt;
        int         pause_left;
        bit         pa_used;
        bit         ps_used;
        bit         fin;
        logic [3:0] prev;
        seq_q.delete();
        soap_len = 0; soap_moff = 0; spin_len = 0; spin_moff = 0; spin_doff = 0;
        lock_drops = 0; water_passes = 0; rinse_at_spin = -1; rinse_at_chk = -1;
        for (int i = 0; i < 4; i++) water_len[i] = 0;
        in_cnt = 0; pause_left = 0; pa_used = 1'b0; ps_used = 1'b0; fin = 1'b0;
        prev = state;
        start = 1'b1;
        door_close = 1'b1;
        for (int c = 0; c < budget && !fin; c++) begin
            filled          = (state == 4'd2) && (in_cnt >= 2);
            detergent_added = (state == 4'd3) && (in_cnt >= 2);
            drained         = (state == 4'd5) && (in_cnt >= 2);
            if (opt_door_drop && state == 4'd5 && in_cnt == 2) door_close = 1'b0;
            if (opt_pause_agit && !pa_used && state == 4'd4 && soap_wash && in_cnt == 2) begin
                pause_left = 5; pa_used = 1'b1;
            end
            if (opt_pause_spin && !ps_used && state == 4'd6 && in_cnt == 2) begin
                pause_left = 5; ps_used = 1'b1;
            end
            pause = (pause_left > 0);
            if (pause_left > 0) pause_left--;
            step();
            if (state != prev) begin
                seq_q.push_back(state);
                in_cnt = 0;
                if (state == 4'd1) rinse_at_chk = int'(rinse_left);
                if (state == 4'd6) rinse_at_spin = int'(rinse_left);
                if (state == 4'd4 && water_wash) water_passes++;
            end else begin
                in_cnt++;
            end
            prev = state;
            if (state == 4'd4 && soap_wash) begin
                soap_len++;
                if (!motor_on) soap_moff++;
            end
            if (state == 4'd4 && water_wash && water_passes >= 1 && water_passes <= 4)
                water_len[water_passes-1]++;
            if (state == 4'd6) begin
                spin_len++;
                if (!motor_on) spin_moff++;
                if (!drain_valve_on) spin_doff++;
            end
            if (state >= 4'd2 && state <= 4'd6 && !door_lock) lock_drops++;
            if (opt_reset_spin && state == 4'd6 && in_cnt == 2) begin
                #3;
                reset = 1'b1;
                #1;
                check("rst_spin_state", state, 4'd0);
                check("rst_spin_outs", outs_vec(), 8'h00);
                fin = 1'b1;
            end
            if (state == 4'd7 || state == 4'd8) fin = 1'b1;
        end
        check("run_end", fin, 1'b1);
        pause = 1'b0; filled = 1'b0; drained = 1'b0; detergent_added = 1'b0;
        door_close = 1'b1;
    endtask

    task automatic back_to_idle(input string tag);
        step();
        check({tag, "_done_hold"}, state, 4'd7);
        start = 1'b0;
        step();
        check({tag, "_idle"}, state, 4'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; door_close = 1'b0; pause = 1'b0;
        filled = 1'b0; drained = 1'b0; detergent_added = 1'b0; rinse_sel = '0;
        opt_pause_agit = 1'b0; opt_pause_spin = 1'b0;
        opt_door_drop = 1'b0; opt_reset_spin = 1'b0;
        #12;
        check("reset_state", state, 4'd0);
        check("reset_outs", outs_vec(), 8'h00);
        check("reset_rinse", rinse_left, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        // Normal run, two rinses
        rinse_sel = 2'd2;
        run_prog(300);
        check("r2_len", seq_q.size(), 13);
        for (int i = 0; i < 13; i++)
            check($sformatf("r2_seq%0d", i), (seq_q.size() > i) ? seq_q[i] : 4'hF, exp_seq2[i]);
        check("r2_chk_rinse", rinse_at_chk, 2);
        check("r2_soap_len", soap_len, 8);
        check("r2_water_passes", water_passes, 2);
        check("r2_water0", water_len[0], 4);
        check("r2_water1", water_len[1], 4);
        check("r2_spin_len", spin_len, 6);
        check("r2_spin_rinse", rinse_at_spin, 0);
        check("r2_lock", lock_drops, 0);
        check("r2_done", done, 1'b1);
        check("r2_unlock", door_lock, 1'b0);
        back_to_idle("r2");

        // Three rinses
        rinse_sel = 2'd3;
        run_prog(300);
        check("r3_len", seq_q.size(), 16);
        check("r3_chk_rinse", rinse_at_chk, 3);
        check("r3_water_passes", water_passes, 3);
        check("r3_last", (seq_q.size() == 16) ? seq_q[15] : 4'hF, 4'd7);
        back_to_idle("r3");

        // No rinse: DRAIN goes straight to SPIN
        rinse_sel = 2'd0;
        run_prog(300);
        check("r0_len", seq_q.size(), 7);
        check("r0_drain_spin", (seq_q.size() == 7) ? {seq_q[4], seq_q[5]} : 8'hFF, 8'h56);
        check("r0_spin_rinse", rinse_at_spin, 0);
        check("r0_water_passes", water_passes, 0);
        back_to_idle("r0");

        // Pause 5 cycles in soap agitate and in spin
        opt_pause_agit = 1'b1; opt_pause_spin = 1'b1;
        run_prog(300);
        opt_pause_agit = 1'b0; opt_pause_spin = 1'b0;
        check("p_soap_len", soap_len, 13);
        check("p_soap_moff", soap_moff, 5);
        check("p_spin_len", spin_len, 11);
        check("p_spin_moff", spin_moff, 5);
        check("p_spin_doff", spin_doff, 5);
        check("p_lock", lock_drops, 0);
        back_to_idle("p");

        // Fill watchdog
        start = 1'b1; door_close = 1'b1; filled = 1'b0;
        step();
        check("ft_chk", state, 4'd1);
        step();
        check("ft_fill", state, 4'd2);
        check("ft_valve", fill_valve_on, 1'b1);
        repeat (9) step();
        check("ft_fill9", state, 4'd2);
        step();
        check("ft_fault", state, 4'd8);
        check("ft_outs", outs_vec(), 8'h81);
        start = 1'b0;
        repeat (3) step();
        check("ft_latched", state, 4'd8);
        #2;
        reset = 1'b1;
        #1;
        check("ft_rst_state", state, 4'd0);
        check("ft_rst_outs", outs_vec(), 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Door opened in DRAIN while drained is also high
        rinse_sel = 2'd0;
        opt_door_drop = 1'b1;
        run_prog(300);
        opt_door_drop = 1'b0;
        check("dd_len", seq_q.size(), 6);
        check("dd_pair", (seq_q.size() == 6) ? {seq_q[4], seq_q[5]} : 8'hFF, 8'h58);
        check("dd_error", error, 1'b1);
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Async reset mid-spin, then a full program again
        rinse_sel = 2'd2;
        opt_reset_spin = 1'b1;
        run_prog(300);
        opt_reset_spin = 1'b0;
        check("rs_last", (seq_q.size() > 0) ? seq_q[seq_q.size()-1] : 4'hF, 4'd6);
        #3;
        reset = 1'b0;
        run_prog(300);
        check("rs2_len", seq_q.size(), 13);
        for (int i = 0; i < 13; i++)
            check($sformatf("rs2_seq%0d", i), (seq_q.size() > i) ? seq_q[i] : 4'hF, exp_seq2[i]);
        check("rs2_done", done, 1'b1);
        back_to_idle("rs2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
